dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin grant, one access per 3 cycles,
// misaligned accesses answered with an error instead of reaching memory.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_last_gnt;
    logic              r_id;
    logic              r_err;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [1:0]        r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err_o;

    logic [1:0]        w_gnt;
    logic              w_sel;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_mis;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

    // Grant decode: only in IDLE and never while reset is held.
    always_comb begin
        w_gnt = 2'b00;
        if (!rst && (r_state == S_IDLE)) begin
            case (req_i)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_last_gnt ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end else begin
            w_gnt = 2'b00;
        end
    end

    // Select the winning requester's attributes.
    always_comb begin
        w_sel       = w_gnt[1];
        w_sel_we    = w_sel ? we_i[1]  : we_i[0];
        w_sel_addr  = w_sel ? addr1_i  : addr0_i;
        w_sel_wdata = w_sel ? wdata1_i : wdata0_i;
        w_sel_mis   = is_misaligned(w_sel_addr[1:0]);
    end

    // Transaction FSM; memory strobes and response fields are registered so
    // they are valid for exactly the ACCESS and RESP cycles respectively.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last_gnt  <= 1'b1;
            r_id        <= 1'b0;
            r_err       <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rvalid    <= 2'b00;
            r_rdata     <= '0;
            r_err_o     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_id  <= w_sel;
                        r_err <= w_sel_mis;
                        if (!w_sel_mis) begin
                            r_mem_read  <= ~w_sel_we;
                            r_mem_write <= w_sel_we;
                            r_mem_addr  <= w_sel_addr;
                            r_mem_wdata <= w_sel_wdata;
                        end else begin
                            r_mem_read  <= 1'b0;
                            r_mem_write <= 1'b0;
                            r_mem_addr  <= '0;
                            r_mem_wdata <= '0;
                        end
                        r_state <= S_ACCESS;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_rvalid    <= r_id ? 2'b10 : 2'b01;
                    // Stores and misaligned accesses return zero data.
                    r_rdata     <= r_mem_read ? mem_rdata_i : '0;
                    r_err_o     <= r_err;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    r_rvalid   <= 2'b00;
                    r_rdata    <= '0;
                    r_err_o    <= 1'b0;
                    r_last_gnt <= r_id;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_rvalid    <= 2'b00;
                    r_rdata     <= '0;
                    r_err_o     <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = w_gnt;
    assign rvalid_o    = r_rvalid;
    assign rdata_o     = r_rdata;
    assign err_o       = r_err_o;
    assign busy_o      = (r_state != S_IDLE);
    assign mem_read_o  = r_mem_read;
    assign mem_write_o = r_mem_write;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset/contention sequences and
// random transactions checked against a round-robin reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_i, we_i;
    logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
    logic [1:0]  gnt_o, rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o, busy_o, mem_read_o, mem_write_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;
    int m_last   = 1;

    typedef struct {
        logic [1:0]  req, we;
        logic [31:0] a0, a1, w0, w1;
        logic [1:0]  egnt;
        logic        erd, ewr;
        logic [31:0] eaddr, ewdata, erdata;
        logic        eerr;
    } vec_t;

    vec_t vecs[6];

    dmem_arbiter dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .busy_o(busy_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tb_mem(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_0F0F;
    endfunction

    assign mem_rdata_i = tb_mem(mem_addr_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one transaction at an IDLE negedge and check all three cycles.
    task automatic run_txn(input logic [1:0] req, input logic [1:0] we,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [1:0] egnt, input logic erd, input logic ewr,
                           input logic [31:0] eaddr, input logic [31:0] ewdata,
                           input logic [31:0] erdata, input logic eerr);
        req_i = req; we_i = we; addr0_i = a0; addr1_i = a1; wdata0_i = w0; wdata1_i = w1;
        #1;
        chk("idle_gnt", 32'(gnt_o), 32'(egnt));
        chk("idle_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        chk("acc_gnt_ignored", 32'(gnt_o), 32'd0);
        chk("acc_busy", 32'(busy_o), 32'd1);
        chk("acc_read", 32'(mem_read_o), 32'(erd));
        chk("acc_write", 32'(mem_write_o), 32'(ewr));
        chk("acc_excl", 32'(mem_read_o & mem_write_o), 32'd0);
        chk("acc_rvalid", 32'(rvalid_o), 32'd0);
        if (erd || ewr) begin
            chk("acc_addr", mem_addr_o, eaddr);
            chk("acc_wdata", mem_wdata_o, ewdata);
        end
        @(negedge clk);
        chk("resp_rvalid", 32'(rvalid_o), 32'(egnt));
        chk("resp_rdata", rdata_o, erdata);
        chk("resp_err", 32'(err_o), 32'(eerr));
        chk("resp_strobes", 32'({mem_read_o, mem_write_o}), 32'd0);
        chk("resp_addr", mem_addr_o, 32'd0);
        req_i = 2'b00;
        if (egnt != 2'b00) m_last = egnt[1] ? 1 : 0;
        @(negedge clk);
        chk("post_rvalid", 32'(rvalid_o), 32'd0);
        chk("post_rdata", rdata_o, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b01, 2'b00, 32'h10, 32'h0,  32'h0,        32'h0,
                    2'b01, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{2'b10, 2'b10, 32'h0,  32'h20, 32'h0,        32'h1234_5678,
                    2'b10, 1'b0, 1'b1, 32'h20, 32'h1234_5678, 32'h0, 1'b0};
        vecs[2] = '{2'b01, 2'b00, 32'h13, 32'h0,  32'h0,        32'h0,
                    2'b01, 1'b0, 1'b0, 32'h0,  32'h0, 32'h0, 1'b1};
        vecs[3] = '{2'b11, 2'b00, 32'h40, 32'h44, 32'h1111,     32'h2222,
                    2'b10, 1'b1, 1'b0, 32'h44, 32'h2222, tb_mem(32'h44), 1'b0};
        vecs[4] = '{2'b11, 2'b01, 32'h48, 32'h4C, 32'hCAFE_F00D, 32'h3333,
                    2'b01, 1'b0, 1'b1, 32'h48, 32'hCAFE_F00D, 32'h0, 1'b0};
        vecs[5] = '{2'b10, 2'b00, 32'h0,  32'h2,  32'h0,        32'h0,
                    2'b10, 1'b0, 1'b0, 32'h0,  32'h0, 32'h0, 1'b1};

        rst = 1'b1; req_i = 2'b01; we_i = 2'b00;
        addr0_i = 32'h0; addr1_i = 32'h0; wdata0_i = 32'h0; wdata1_i = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_strobes", 32'({mem_read_o, mem_write_o}), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        rst = 1'b0;

        // Directed table, first vector on the first edge after reset release.
        m_last = 1;
        for (int i = 0; i < 6; i++)
            run_txn(vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].w0, vecs[i].w1,
                    vecs[i].egnt, vecs[i].erd, vecs[i].ewr, vecs[i].eaddr, vecs[i].ewdata,
                    vecs[i].erdata, vecs[i].eerr);

        // Contention from reset: both requesting continuously.
        rst = 1'b1; req_i = 2'b11; we_i = 2'b00;
        addr0_i = 32'h100; addr1_i = 32'h200;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("rr_gnt", 32'(gnt_o), (c % 3 != 0) ? 32'd0 : (((c / 3) % 2 == 0) ? 32'd1 : 32'd2));
            @(negedge clk);
        end
        req_i = 2'b00;
        m_last = 1;

        // Reset in the ACCESS cycle of a store.
        req_i = 2'b10; we_i = 2'b10; addr1_i = 32'h20; wdata1_i = 32'h1234_5678;
        #1;
        chk("ab_gnt", 32'(gnt_o), 32'd2);
        @(negedge clk);
        chk("ab_write", 32'(mem_write_o), 32'd1);
        req_i = 2'b11; we_i = 2'b00; addr0_i = 32'h10;
        #2;
        rst = 1'b1;
        #1;
        chk("ab_write_drop", 32'(mem_write_o), 32'd0);
        chk("ab_busy", 32'(busy_o), 32'd0);
        chk("ab_gnt_rst", 32'(gnt_o), 32'd0);
        @(negedge clk);
        chk("ab_no_rvalid", 32'(rvalid_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("ab_regrant", 32'(gnt_o), 32'd1);
        @(negedge clk);
        chk("ab_read", 32'(mem_read_o), 32'd1);
        @(negedge clk);
        chk("ab_rdata", rdata_o, 32'hDEAD_BEEF);
        req_i = 2'b00;
        m_last = 0;
        @(negedge clk);

        // Random transactions against the round-robin reference model.
        for (int t = 0; t < 40; t++) begin
            logic [1:0]  rq, wv, g;
            logic [31:0] a0, a1, w0, w1, sa, sw;
            logic        sid, swe, mis, erd, ewr;
            if ($urandom_range(0, 4) == 0) begin
                req_i = 2'b00;
                #1;
                chk("rnd_idle_gnt", 32'(gnt_o), 32'd0);
                @(negedge clk);
            end
            rq = 2'($urandom_range(1, 3));
            wv = 2'($urandom_range(0, 3));
            a0 = $urandom() & 32'hFFFF_FFFC;
            a1 = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) a0 = a0 | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a1 = a1 | 32'($urandom_range(0, 3));
            w0 = $urandom();
            w1 = $urandom();
            sid = (rq == 2'b11) ? (m_last == 0) : (rq == 2'b10);
            g   = sid ? 2'b10 : 2'b01;
            sa  = sid ? a1 : a0;
            sw  = sid ? w1 : w0;
            swe = sid ? wv[1] : wv[0];
            mis = (sa % 4) != 0;
            erd = !mis && !swe;
            ewr = !mis && swe;
            run_txn(rq, wv, a0, a1, w0, w1, g, erd, ewr, sa, sw,
                    erd ? tb_mem(sa) : 32'h0, mis);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
